// File: rtl/step_enable_gen_pkg.sv
//------------------------------------------------------------------------------
// Module  : step_enable_gen_pkg
// Brief   : Shared state codes and idle input levels for the step enable
//           generator and any status logic that decodes its state.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package step_enable_gen_pkg;

    // Controller states, 2-bit encoded so status LEDs can decode them directly.
    typedef enum logic [1:0] {
        ST_MANUAL     = 2'd0,
        ST_RUN_PAUSED = 2'd1,
        ST_RUNNING    = 2'd2,
        ST_HALTED     = 2'd3
    } state_t;

    // Idle (released / manual) levels of the raw board controls.
    localparam logic BTN_IDLE = 1'b1;
    localparam logic SEL_IDLE = 1'b0;

endpackage

`default_nettype wire

// File: rtl/step_enable_gen_btn_debounce.sv
//------------------------------------------------------------------------------
// Module  : step_enable_gen_btn_debounce
// Brief   : Multi-flop synchronizer followed by a level debouncer. The output
//           level follows the synchronized input only after it has disagreed
//           for DEBOUNCE_CYCLES consecutive cycles.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module step_enable_gen_btn_debounce
    import step_enable_gen_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic IDLE            = BTN_IDLE
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   w_synced;

    assign w_synced = r_sync[SYNC_STAGES-1];

    // Shift the asynchronous input through the synchronizer chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{IDLE}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], din};
        end
    end

    // Accept a new level only after a full run of disagreeing cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            level <= IDLE;
        end else if (w_synced == level) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            level <= w_synced;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/step_enable_gen.sv
//------------------------------------------------------------------------------
// Module  : step_enable_gen
// Brief   : Enable-based clock controller for the CPU datapath. Turns the
//           start pushbutton and run/manual switch into one-cycle step_en
//           pulses (manual single-step or free-running divider), honours CPU
//           halt requests and reports status. The fabric clock is never gated.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module step_enable_gen
    import step_enable_gen_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int RUN_DIV         = 25000000,
    parameter int STEP_W          = 32
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              start_button,
    input  logic              clk_select,
    input  logic              halt_req,
    output logic              step_en,
    output logic              running,
    output logic              halted,
    output logic [STEP_W-1:0] step_count
);

    localparam int               DIV_W    = $clog2(RUN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    logic             w_btn_level;
    logic             w_sel_level;
    logic             r_btn_prev;
    logic             r_press;
    state_t           r_state;
    logic [DIV_W-1:0] r_div;

    step_enable_gen_btn_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .IDLE            (BTN_IDLE)
    ) u_btn_db (
        .clk   (clk_in),
        .rst   (reset),
        .din   (start_button),
        .level (w_btn_level)
    );

    step_enable_gen_btn_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .IDLE            (SEL_IDLE)
    ) u_sel_db (
        .clk   (clk_in),
        .rst   (reset),
        .din   (clk_select),
        .level (w_sel_level)
    );

    // Registered one-cycle press pulse on the debounced 1->0 button edge.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_btn_prev <= BTN_IDLE;
            r_press    <= 1'b0;
        end else begin
            r_btn_prev <= w_btn_level;
            r_press    <= r_btn_prev & ~w_btn_level;
        end
    end

    // Controller FSM with run divider; switch beats halt beats press beats divider.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state <= ST_MANUAL;
            r_div   <= '0;
            step_en <= 1'b0;
            running <= 1'b0;
            halted  <= 1'b0;
        end else begin
            step_en <= 1'b0;
            case (r_state)
                ST_MANUAL: begin
                    if (w_sel_level) begin
                        r_state <= ST_RUN_PAUSED;
                    end else if (r_press) begin
                        step_en <= 1'b1;
                    end
                end
                ST_RUN_PAUSED: begin
                    if (!w_sel_level) begin
                        r_state <= ST_MANUAL;
                    end else if (r_press) begin
                        r_state <= ST_RUNNING;
                        running <= 1'b1;
                        r_div   <= '0;
                    end
                end
                ST_RUNNING: begin
                    if (!w_sel_level) begin
                        r_state <= ST_MANUAL;
                        running <= 1'b0;
                        r_div   <= '0;
                    end else if (halt_req) begin
                        r_state <= ST_HALTED;
                        running <= 1'b0;
                        halted  <= 1'b1;
                        r_div   <= '0;
                    end else if (r_press) begin
                        r_state <= ST_RUN_PAUSED;
                        running <= 1'b0;
                        r_div   <= '0;
                    end else if (r_div == DIV_LAST) begin
                        r_div   <= '0;
                        step_en <= 1'b1;
                    end else begin
                        r_div   <= r_div + DIV_W'(1);
                    end
                end
                ST_HALTED: begin
                    if (!w_sel_level) begin
                        r_state <= ST_MANUAL;
                        halted  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_MANUAL;
                    r_div   <= '0;
                    running <= 1'b0;
                    halted  <= 1'b0;
                end
            endcase
        end
    end

    // Count issued steps; wraps naturally at the counter width.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            step_count <= '0;
        end else if (step_en) begin
            step_count <= step_count + STEP_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_step_enable_gen.sv
//------------------------------------------------------------------------------
// Module  : tb_step_enable_gen
// Brief   : Directed self-checking bench for step_enable_gen using a queue of
//           expected values and immediate assertions at each sample point.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_step_enable_gen;

    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int RUN_DIV         = 5;
    localparam int STEP_W          = 4;

    logic              clk_in       = 1'b0;
    logic              reset        = 1'b1;
    logic              start_button = 1'b1;
    logic              clk_select   = 1'b0;
    logic              halt_req     = 1'b0;
    logic              step_en;
    logic              running;
    logic              halted;
    logic [STEP_W-1:0] step_count;

    int                checks = 0;
    int                errors = 0;
    logic [31:0]       exp_q[$];
    string             tag_q[$];
    logic [STEP_W-1:0] model_cnt = '0;

    step_enable_gen #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RUN_DIV         (RUN_DIV),
        .STEP_W          (STEP_W)
    ) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .start_button (start_button),
        .clk_select   (clk_select),
        .halt_req     (halt_req),
        .step_en      (step_en),
        .running      (running),
        .halted       (halted),
        .step_count   (step_count)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push_exp(input string tag, input logic [31:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed %0d required none", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed %0d required %0d", t, obs, e);
            end
        end
    endtask

    // One clock with an expected step_en value for the resulting cycle.
    task automatic cyc(input logic exp_step, input string tag);
        push_exp(tag, {31'd0, exp_step});
        tick();
        pop_check({31'd0, step_en});
        if (exp_step) model_cnt = model_cnt + 4'd1;
    endtask

    task automatic check_status(input logic exp_run, input logic exp_halt, input string tag);
        push_exp({tag, "_running"}, {31'd0, exp_run});
        push_exp({tag, "_halted"}, {31'd0, exp_halt});
        pop_check({31'd0, running});
        pop_check({31'd0, halted});
    endtask

    task automatic check_count(input string tag);
        push_exp({tag, "_count"}, {28'd0, model_cnt});
        pop_check({28'd0, step_count});
    endtask

    // Manual single-step: 8 low samples then 8 high; step lands on the 8th edge.
    task automatic manual_press(input string tag);
        for (int i = 0; i < 16; i++) begin
            start_button = (i < 8) ? 1'b0 : 1'b1;
            cyc(i == 7, tag);
        end
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(1'b0, tag);
    endtask

    initial begin
        // Test 1a: power-on reset held two cycles
        tick();
        tick();
        reset = 1'b0;
        check_status(1'b0, 1'b0, "reset");
        check_count("reset");
        push_exp("reset_step_en", 32'd0);
        pop_check({31'd0, step_en});

        // Test 2: 12-cycle press gives one step on the 8th edge; 3-cycle glitch gives none
        for (int i = 0; i < 12; i++) begin
            start_button = 1'b0;
            cyc(i == 7, "manual_latency");
        end
        start_button = 1'b1;
        idle_cycles(10, "manual_release");
        check_count("manual_one");
        for (int i = 0; i < 3; i++) begin
            start_button = 1'b0;
            cyc(1'b0, "glitch");
        end
        start_button = 1'b1;
        idle_cycles(12, "glitch_after");
        check_count("glitch");

        // Test 3: run mode, steps every RUN_DIV cycles, second press pauses
        clk_select = 1'b1;
        idle_cycles(10, "sel_run");
        check_status(1'b0, 1'b0, "run_paused");
        for (int i = 0; i < 46; i++) begin
            start_button = (i < 8 || (i >= 26 && i < 34)) ? 1'b0 : 1'b1;
            cyc((i > 7) && (i <= 32) && ((i - 7) % RUN_DIV == 0), "run_steps");
            if (i == 8)  check_status(1'b1, 1'b0, "run_entered");
            if (i == 34) check_status(1'b0, 1'b0, "run_paused_again");
        end
        check_count("run");
        idle_cycles(5, "run_gap");

        // Test 4: halt on a terminal cycle suppresses that step; press ignored while halted
        for (int i = 0; i < 31; i++) begin
            start_button = (i < 8) ? 1'b0 : 1'b1;
            halt_req     = (i == 17) ? 1'b1 : 1'b0;
            cyc(i == 12, "halt_steps");
            if (i == 17) check_status(1'b0, 1'b1, "halt_entered");
        end
        halt_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            start_button = (i < 8) ? 1'b0 : 1'b1;
            cyc(1'b0, "halted_press");
        end
        check_status(1'b0, 1'b1, "halted_hold");
        clk_select = 1'b0;
        idle_cycles(10, "halt_to_manual");
        check_status(1'b0, 1'b0, "halt_cleared");
        check_count("halt");

        // Test 1b: reset in the middle of a run
        clk_select = 1'b1;
        idle_cycles(10, "sel_run2");
        for (int i = 0; i < 15; i++) begin
            start_button = (i < 8) ? 1'b0 : 1'b1;
            cyc(i == 12, "prerst_steps");
        end
        check_status(1'b1, 1'b0, "prerst_running");
        clk_select = 1'b0;
        reset      = 1'b1;
        tick();
        tick();
        reset      = 1'b0;
        model_cnt  = '0;
        check_status(1'b0, 1'b0, "midrun_reset");
        check_count("midrun_reset");
        push_exp("midrun_reset_step_en", 32'd0);
        pop_check({31'd0, step_en});
        idle_cycles(20, "after_reset");

        // Test 5: sixteen manual steps wrap the 4-bit counter
        for (int p = 0; p < 16; p++) begin
            manual_press("wrap_press");
            if (p == 14) begin
                push_exp("wrap_15", 32'd15);
                pop_check({28'd0, step_count});
            end
            if (p == 15) begin
                push_exp("wrap_0", 32'd0);
                pop_check({28'd0, step_count});
            end
        end

        // Test 6: pause press coinciding with a terminal cycle, then clean resume
        clk_select = 1'b1;
        idle_cycles(10, "sel_run3");
        for (int i = 0; i < 41; i++) begin
            start_button = (i < 8 || (i >= 20 && i < 28)) ? 1'b0 : 1'b1;
            cyc(i == 12 || i == 17 || i == 22, "coincide_steps");
            if (i == 26) check_status(1'b1, 1'b0, "coincide_before");
            if (i == 27) check_status(1'b0, 1'b0, "coincide_paused");
        end
        for (int i = 0; i < 16; i++) begin
            start_button = (i < 8) ? 1'b0 : 1'b1;
            cyc(i == 12, "resume_steps");
        end
        check_status(1'b1, 1'b0, "resumed");
        check_count("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
